// File: rtl/dpram_port_ctrl_pkg.sv
// Shared definitions for the dual-port RAM port controller: default geometry
// (same macro names as the RAM) and the controller state encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef DEPTH
`define DEPTH 8
`endif

package dpram_port_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEF_ADDR_WIDTH = `ADDR_WIDTH;
   localparam int DEF_DEPTH      = `DEPTH;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_CLEAR  = 2'd2
   } state_t;

endpackage

// File: rtl/dpram_port_ctrl_if.sv
// Command and response channels between an initiator and the RAM port controller.
interface dpram_port_ctrl_if
   import dpram_port_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/dpram_port_ctrl_resp_fifo2.sv
// Two-entry synchronous FIFO holding read data until the consumer takes it.
module resp_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             pop;

   assign valid = (count != 2'd0);
   assign pop   = valid && ready;
   assign data  = mem[rd_ptr];

   // Storage is cleared on reset so the output data reads zero until the first push.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dpram_port_ctrl.sv
// Initiator-side controller for one RAM port: command stream to RAM cycles,
// backpressured read responses, and a one-word-per-clock clear sweep.
module dpram_port_ctrl
   import dpram_port_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   dpram_port_ctrl_if.slave      cmd_bus,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  inflight;
   logic [1:0]            fifo_count;
   logic                  cmd_ready;
   logic                  cmd_fire;
   logic                  rd_fire;
   logic                  clr_last;

   // At most two reads may be buffered or in flight, so the FIFO can never overflow.
   assign cmd_ready         = (state == ST_ACTIVE) &&
                              (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
   assign cmd_bus.cmd_ready = cmd_ready;
   assign cmd_fire          = cmd_bus.cmd_valid && cmd_ready;
   assign rd_fire           = cmd_fire && !cmd_bus.cmd_we;
   assign clr_last          = (clr_cnt == ADDR_WIDTH'(DEPTH - 1));
   assign clr_busy          = (state != ST_ACTIVE);

   always_comb begin
      ram_addr = cmd_bus.cmd_addr;
      ram_din  = cmd_bus.cmd_wdata;
      ram_we   = 1'b0;
      case (state)
         ST_ACTIVE: ram_we = cmd_fire && cmd_bus.cmd_we;
         ST_CLEAR: begin
            ram_addr = clr_cnt;
            ram_din  = '0;
            ram_we   = 1'b1;
         end
         default: ram_we = 1'b0;
      endcase
      if (rst) begin
         ram_we = 1'b0;
      end
   end

   // DRAIN lasts one cycle: any read accepted with clr_start retires on that same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_ACTIVE;
         clr_cnt  <= '0;
         inflight <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         inflight <= rd_fire;
         case (state)
            ST_ACTIVE: begin
               if (clr_start) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               if (clr_last) begin
                  clr_cnt  <= '0;
                  clr_done <= 1'b1;
                  state    <= ST_ACTIVE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: state <= ST_ACTIVE;
         endcase
      end
   end

   resp_fifo2 #(
      .WIDTH(DATA_WIDTH)
   ) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data(ram_dout),
      .valid    (cmd_bus.rsp_valid),
      .ready    (cmd_bus.rsp_ready),
      .data     (cmd_bus.rsp_rdata),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Directed bench for dpram_port_ctrl with a behavioural read-before-write RAM
// model on the port side.
module tb_dpram_port_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr_start;
   logic       clr_busy;
   logic       clr_done;
   logic [2:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;

   logic [7:0] ram_mem [8];
   logic       mem_loaded = 1'b0;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic       rr;
      logic       exp_ready;
      logic       exp_we;
      logic       exp_rv;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   dpram_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   dpram_port_ctrl #(
      .DATA_WIDTH    (8),
      .ADDR_WIDTH    (3),
      .DEPTH         (8),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_bus  (bus),
      .clr_start(clr_start),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // Registered-read RAM; old contents are nonzero so a clear is observable.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 8; i++) ram_mem[i] <= 8'hF0 | 8'(i);
         mem_loaded <= 1'b1;
      end else begin
         ram_dout <= ram_mem[ram_addr];
         if (ram_we) ram_mem[ram_addr] <= ram_din;
      end
   end

   function automatic vec_t mkVec(logic v, logic w, logic [2:0] a, logic [7:0] d, logic r,
                                  logic er, logic ew, logic ev, logic [7:0] ed);
      vec_t t;
      t.valid = v; t.we = w; t.addr = a; t.wdata = d; t.rr = r;
      t.exp_ready = er; t.exp_we = ew; t.exp_rv = ev; t.exp_rd = ed;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.cmd_valid = v.valid;
      bus.cmd_we    = v.we;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.rsp_ready = v.rr;
   endtask

   task automatic runSweep(input int first, input int n);
      for (int k = 0; k < n; k++) begin
         #1;
         checkOutput("sweep_we", ram_we, 1);
         checkOutput("sweep_addr", ram_addr, first + k);
         checkOutput("sweep_din", ram_din, 0);
         checkOutput("sweep_busy", clr_busy, 1);
         checkOutput("sweep_cmd_ready", bus.cmd_ready, 0);
         checkOutput("sweep_done_low", clr_done, 0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      clr_start = 1'b0;
      applyStimulus(mkVec(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));

      // Reset state
      tick();
      checkOutput("rst_busy", clr_busy, 1);
      checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
      checkOutput("rst_clr_done", clr_done, 0);
      checkOutput("rst_ram_we", ram_we, 0);
      tick();
      rst = 1'b0;

      // Automatic sweep after reset; a clr_start mid-sweep must be ignored
      runSweep(0, 2);
      clr_start = 1'b1;
      runSweep(2, 1);
      clr_start = 1'b0;
      runSweep(3, 5);
      #1;
      checkOutput("post_rst_done", clr_done, 1);
      checkOutput("post_rst_ready", bus.cmd_ready, 1);
      checkOutput("post_rst_busy", clr_busy, 0);
      checkOutput("post_rst_we", ram_we, 0);
      tick();
      checkOutput("done_one_pulse", clr_done, 0);

      // Cycle-by-cycle command/response table
      vecs.push_back(mkVec(1, 0, 5, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h00));
      vecs.push_back(mkVec(1, 1, 3, 8'hA5, 1, 1, 1, 0, 8'h00));
      vecs.push_back(mkVec(1, 0, 3, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'hA5));
      vecs.push_back(mkVec(1, 1, 7, 8'h3C, 1, 1, 1, 0, 8'h00));
      vecs.push_back(mkVec(1, 0, 7, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h3C));
      vecs.push_back(mkVec(1, 1, 1, 8'h11, 1, 1, 1, 0, 8'h00));
      vecs.push_back(mkVec(1, 1, 2, 8'h22, 1, 1, 1, 0, 8'h00));
      vecs.push_back(mkVec(1, 1, 3, 8'h33, 1, 1, 1, 0, 8'h00));
      vecs.push_back(mkVec(1, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(1, 0, 2, 8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(1, 0, 3, 8'h00, 0, 0, 0, 1, 8'h11));
      vecs.push_back(mkVec(1, 0, 3, 8'h00, 0, 0, 0, 1, 8'h11));
      vecs.push_back(mkVec(1, 0, 3, 8'h00, 1, 0, 0, 1, 8'h11));
      vecs.push_back(mkVec(1, 0, 3, 8'h00, 1, 1, 0, 1, 8'h22));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h33));
      vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d_cmd_ready", i), bus.cmd_ready, vecs[i].exp_ready);
         checkOutput($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
         checkOutput($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, vecs[i].exp_rv);
         if (vecs[i].exp_rv) begin
            checkOutput($sformatf("vec%0d_rsp_rdata", i), bus.rsp_rdata, vecs[i].exp_rd);
         end
         tick();
      end

      // Read accepted together with clr_start returns pre-clear data
      applyStimulus(mkVec(1, 1, 4, 8'h44, 1, 0, 0, 0, 8'h00));
      #1;
      checkOutput("w44_we", ram_we, 1);
      tick();
      applyStimulus(mkVec(1, 0, 4, 8'h00, 1, 0, 0, 0, 8'h00));
      clr_start = 1'b1;
      #1;
      checkOutput("clr_rd_ready", bus.cmd_ready, 1);
      checkOutput("clr_rd_busy", clr_busy, 0);
      tick();
      clr_start = 1'b0;
      bus.cmd_valid = 1'b0;
      #1;
      checkOutput("drain_busy", clr_busy, 1);
      checkOutput("drain_ready", bus.cmd_ready, 0);
      checkOutput("drain_we", ram_we, 0);
      checkOutput("drain_rsp_valid", bus.rsp_valid, 0);
      tick();
      applyStimulus(mkVec(1, 1, 6, 8'hFF, 1, 0, 0, 0, 8'h00));
      #1;
      checkOutput("clr_rsp_valid", bus.rsp_valid, 1);
      checkOutput("clr_rsp_rdata", bus.rsp_rdata, 8'h44);
      runSweep(0, 8);
      bus.cmd_valid = 1'b0;
      #1;
      checkOutput("clr2_done", clr_done, 1);
      checkOutput("clr2_busy", clr_busy, 0);
      tick();

      // Reset mid-sweep with a buffered response
      applyStimulus(mkVec(1, 1, 2, 8'h5A, 0, 0, 0, 0, 8'h00));
      tick();
      applyStimulus(mkVec(1, 0, 2, 8'h00, 0, 0, 0, 0, 8'h00));
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      bus.cmd_valid = 1'b0;
      tick();
      runSweep(0, 4);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_addr", ram_addr, 4);
      checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 1);
      checkOutput("mid_rst_rsp_rdata", bus.rsp_rdata, 8'h5A);
      checkOutput("mid_rst_we", ram_we, 0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("after_rst_rsp_valid", bus.rsp_valid, 0);
      runSweep(0, 8);
      #1;
      checkOutput("after_rst_done", clr_done, 1);
      checkOutput("after_rst_rsp_valid_end", bus.rsp_valid, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
